// File: rtl/cmv_frame_sequencer_if.sv
// Control/status bundle between the host and cmv_frame_sequencer, including the sensor pins.
// The master side (host or bench) drives the i_* signals; the sequencer (slave) drives the o_* signals.
interface cmv_frame_sequencer_if #(
  parameter int LINE_W  = 10,
  parameter int FRAME_W = 16
);
  logic               i_start;
  logic               i_stop;
  logic [FRAME_W-1:0] i_num_frames;
  logic [LINE_W-1:0]  i_lines_per_frame;
  logic               i_lval;
  logic               o_clk_in;
  logic               o_sys_res;
  logic               o_frame_req;
  logic               o_capture_en;
  logic               o_ready;
  logic               o_busy;
  logic               o_frame_done;
  logic [FRAME_W-1:0] o_frame_cnt;
  logic               o_timeout;

  modport master (
    output i_start, i_stop, i_num_frames, i_lines_per_frame, i_lval,
    input  o_clk_in, o_sys_res, o_frame_req, o_capture_en, o_ready, o_busy,
           o_frame_done, o_frame_cnt, o_timeout
  );

  modport slave (
    input  i_start, i_stop, i_num_frames, i_lines_per_frame, i_lval,
    output o_clk_in, o_sys_res, o_frame_req, o_capture_en, o_ready, o_busy,
           o_frame_done, o_frame_cnt, o_timeout
  );
endinterface

// File: rtl/cmv_frame_sequencer.sv
// CMV300-class sensor sequencer: clock divider, sys_res power-up, frame requests and LVAL line counting.
// Defining CMV_FRAME_TIMEOUT_EN adds a per-frame watchdog that drives the sticky o_timeout flag.
module cmv_frame_sequencer #(
  parameter int CLK_DIVIDER   = 4,
  parameter int RESET_CYCLES  = 64,
  parameter int SETTLE_CYCLES = 4096,
  parameter int REQ_CYCLES    = 2,
  parameter int GAP_CYCLES    = 16,
  parameter int LINE_W        = 10,
  parameter int FRAME_W       = 16
`ifdef CMV_FRAME_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1 << 20
`endif
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  cmv_frame_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    ST_RESET, ST_SETTLE, ST_READY, ST_REQ, ST_FRAME, ST_GAP
  } state_e;

  // One shared cycle counter serves every timed state, so it is sized for the longest wait.
  localparam int MAX_A = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
  localparam int MAX_B = (REQ_CYCLES > GAP_CYCLES) ? REQ_CYCLES : GAP_CYCLES;
  localparam int MAX_AB = (MAX_A > MAX_B) ? MAX_A : MAX_B;
`ifdef CMV_FRAME_TIMEOUT_EN
  localparam int CNT_MAX = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
`else
  localparam int CNT_MAX = MAX_AB;
`endif
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] RESET_LAST  = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] REQ_LAST    = CNT_W'(REQ_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
`ifdef CMV_FRAME_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  localparam int HALF  = CLK_DIVIDER / 2;
  localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF - 1);

  logic [DIV_W-1:0] div_q;
  logic             clk_in_q;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      div_q    <= '0;
      clk_in_q <= 1'b0;
    end else if (div_q == DIV_LAST) begin
      div_q    <= '0;
      clk_in_q <= ~clk_in_q;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  logic lval_meta_q, lval_sync_q, lval_prev_q;
  logic lval_fall;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lval_meta_q <= 1'b0;
      lval_sync_q <= 1'b0;
      lval_prev_q <= 1'b0;
    end else begin
      lval_meta_q <= bus.i_lval;
      lval_sync_q <= lval_meta_q;
      lval_prev_q <= lval_sync_q;
    end
  end

  assign lval_fall = lval_prev_q & ~lval_sync_q;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LINE_W-1:0]  line_cnt_q, line_cnt_d;
  logic [LINE_W-1:0]  lines_q, lines_d;
  logic [FRAME_W-1:0] num_frames_q, num_frames_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic               stop_pend_q, stop_pend_d;
  logic               timeout_q, timeout_d;
  logic               frame_done_d;
  logic               in_run;

  assign in_run = (state_q == ST_REQ) || (state_q == ST_FRAME) || (state_q == ST_GAP);

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_W'(1);
    line_cnt_d   = line_cnt_q;
    lines_d      = lines_q;
    num_frames_d = num_frames_q;
    frame_cnt_d  = frame_cnt_q;
    stop_pend_d  = stop_pend_q | (bus.i_stop & in_run);
    timeout_d    = timeout_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      ST_RESET: if (cnt_q == RESET_LAST) begin
        state_d = ST_SETTLE;
        cnt_d   = '0;
      end
      ST_SETTLE: if (cnt_q == SETTLE_LAST) begin
        state_d = ST_READY;
        cnt_d   = '0;
      end
      ST_READY: begin
        cnt_d = '0;
        if (bus.i_start) begin
          state_d      = ST_REQ;
          lines_d      = (bus.i_lines_per_frame == '0) ? LINE_W'(1) : bus.i_lines_per_frame;
          num_frames_d = bus.i_num_frames;
          frame_cnt_d  = '0;
          line_cnt_d   = '0;
          stop_pend_d  = 1'b0;
          timeout_d    = 1'b0;
        end
      end
      ST_REQ: if (cnt_q == REQ_LAST) begin
        state_d = ST_FRAME;
        cnt_d   = '0;
      end
      ST_FRAME: begin
        if (lval_fall && (line_cnt_q + LINE_W'(1) == lines_q)) begin
          state_d      = ST_GAP;
          cnt_d        = '0;
          frame_done_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + FRAME_W'(1);
        end else begin
          if (lval_fall) line_cnt_d = line_cnt_q + LINE_W'(1);
`ifdef CMV_FRAME_TIMEOUT_EN
          if (cnt_q == TIMEOUT_LAST) begin
            state_d   = ST_READY;
            cnt_d     = '0;
            timeout_d = 1'b1;
          end
`else
          cnt_d = '0;
`endif
        end
      end
      ST_GAP: if (cnt_q == GAP_LAST) begin
        cnt_d      = '0;
        line_cnt_d = '0;
        if (!stop_pend_d && ((num_frames_q == '0) || (frame_cnt_q < num_frames_q)))
          state_d = ST_REQ;
        else
          state_d = ST_READY;
      end
      default: begin
        state_d = ST_RESET;
        cnt_d   = '0;
      end
    endcase
  end

  logic sys_res_q, ready_q, busy_q, frame_req_q, capture_en_q, frame_done_q;

  // NOTE: pin-level outputs are registered from state_d so they change glitch-free with the state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_RESET;
      cnt_q        <= '0;
      line_cnt_q   <= '0;
      lines_q      <= '0;
      num_frames_q <= '0;
      frame_cnt_q  <= '0;
      stop_pend_q  <= 1'b0;
      timeout_q    <= 1'b0;
      sys_res_q    <= 1'b0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_req_q  <= 1'b0;
      capture_en_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      line_cnt_q   <= line_cnt_d;
      lines_q      <= lines_d;
      num_frames_q <= num_frames_d;
      frame_cnt_q  <= frame_cnt_d;
      stop_pend_q  <= stop_pend_d;
      timeout_q    <= timeout_d;
      sys_res_q    <= (state_d != ST_RESET);
      ready_q      <= (state_d == ST_READY);
      busy_q       <= (state_d == ST_REQ) || (state_d == ST_FRAME) || (state_d == ST_GAP);
      frame_req_q  <= (state_d == ST_REQ);
      capture_en_q <= (state_d == ST_REQ) || (state_d == ST_FRAME);
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.o_clk_in     = clk_in_q;
  assign bus.o_sys_res    = sys_res_q;
  assign bus.o_frame_req  = frame_req_q;
  assign bus.o_capture_en = capture_en_q;
  assign bus.o_ready      = ready_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_frame_done = frame_done_q;
  assign bus.o_frame_cnt  = frame_cnt_q;
`ifdef CMV_FRAME_TIMEOUT_EN
  assign bus.o_timeout    = timeout_q;
`else
  assign bus.o_timeout    = 1'b0;
`endif

endmodule

// File: doc/cmv_frame_sequencer.md
Name: cmv_frame_sequencer

Overview:
- Parametrised control sequencer for CMV300-class CMOS sensors; replaces the fixed one-shot frame trigger.
- Generates the sensor input clock and the sys_res power-up sequence.
- Issues single, N-frame or continuous frame requests, and counts lines from a synchronised LVAL to detect frame completion.
- Sits between host control (endpoint wires/triggers) and the sensor pins. It drives the capture gate consumed by the pixel FIFO write side.

Parameters:
- CLK_DIVIDER, 4: i_clk cycles per o_clk_in period; even, >=2.
- RESET_CYCLES, 64: i_clk cycles o_sys_res is held low after power-up sequencing begins.
- SETTLE_CYCLES, 4096: i_clk cycles from o_sys_res rising to READY.
- REQ_CYCLES, 2: width of the o_frame_req pulse in i_clk cycles; >=1.
- GAP_CYCLES, 16: idle i_clk cycles between consecutive frames.
- LINE_W, 10: width of the line counter and i_lines_per_frame.
- FRAME_W, 16: width of the frame counter and i_num_frames.
- TIMEOUT_CYCLES, 2^20: watchdog limit per frame (optional feature only).

Ports:
- i_clk  in  1  system clock; all logic on its rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_start  in  1  one-cycle pulse; begins an acquisition run when READY.
- i_stop  in  1  one-cycle pulse; ends a run after the current frame.
- i_num_frames  in  FRAME_W  frames per run; 0 = continuous. Sampled at start.
- i_lines_per_frame  in  LINE_W  lines per frame; sampled at start; 0 treated as 1.
- i_lval  in  1  sensor LVAL, asynchronous; double-flop synchronised internally.
- o_clk_in  out  1  sensor clock, 50 % duty.
- o_sys_res  out  1  sensor reset, active-low.
- o_frame_req  out  1  sensor frame request pulse.
- o_capture_en  out  1  gate for the FIFO write enable (ANDed with DVAL externally).
- o_ready  out  1  high in READY.
- o_busy  out  1  high from start acceptance until the run ends.
- o_frame_done  out  1  one-cycle pulse per completed frame.
- o_frame_cnt  out  FRAME_W  frames completed in the current run.
- o_timeout  out  1  sticky watchdog flag (0 when the feature is absent).

Behaviour:
- Reset values (asynchronous assert):
  - o_clk_in=0, o_sys_res=0, o_frame_req=0, o_capture_en=0.
  - o_ready=0, o_busy=0, o_frame_done=0, o_frame_cnt=0, o_timeout=0.
  - All counters 0; state RESET.
- Clock divider: free-running unless in reset. o_clk_in toggles every CLK_DIVIDER/2 i_clk cycles, giving period = CLK_DIVIDER exactly.
- States:
  - RESET: o_sys_res=0; count RESET_CYCLES, then go to SETTLE and set o_sys_res=1.
  - SETTLE: count SETTLE_CYCLES, then go to READY.
  - READY: o_ready=1. On i_start, latch inputs, clear o_frame_cnt, set o_busy=1, go to REQ. i_stop is ignored here.
  - REQ: o_frame_req=1 and o_capture_en=1 for exactly REQ_CYCLES cycles, then go to FRAME. o_capture_en stays 1 through FRAME.
  - FRAME: each falling edge of synchronised LVAL increments the line count. On reaching the latched line count:
    - o_frame_done pulses for one cycle.
    - o_frame_cnt increments, wrapping at 2^FRAME_W.
    - o_capture_en drops in the same cycle.
    - Next state is GAP.
  - GAP: wait GAP_CYCLES. Then go to REQ if continuous (and no stop pending) or if frame_cnt < num_frames. Otherwise go to READY with o_busy=0.
- i_stop during a run sets stop_pending. The current frame completes normally; the run ends after the next GAP. stop_pending is cleared on the next start.
- i_start while busy: ignored.
- i_start and i_stop in the same READY cycle: start wins; stop is ignored.
- An LVAL falling edge outside FRAME is ignored; the line counter clears on REQ entry.
- Latency: from the i_start cycle to o_frame_req rising is 1 cycle (registered).
- Asserting i_rst mid-run aborts immediately. The full sys_res sequence is re-run.

Optional Feature:
- Macro: CMV_FRAME_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles in FRAME.
  - Reaching TIMEOUT_CYCLES sets o_timeout, which is sticky until the next i_start or reset.
  - On timeout, o_capture_en drops, no o_frame_done is issued, o_busy drops, and the state returns to READY.
- Undefined: no watchdog logic; o_timeout is tied to 0; FRAME waits indefinitely.

Test Plan:
- Power-up (CLK_DIVIDER=4, RESET_CYCLES=8, SETTLE_CYCLES=16) -> o_sys_res low for 8 cycles; o_ready rises 16 cycles later; o_clk_in period is 4 cycles.
- i_num_frames=1, i_lines_per_frame=4, 4 LVAL pulses -> one o_frame_req (2 cycles wide), then o_frame_done once, o_frame_cnt=1, back to READY.
- i_num_frames=3 -> 3 requests separated by at least GAP_CYCLES+line time; o_frame_cnt=3; o_busy falls after the third GAP.
- i_num_frames=0, i_stop mid-frame 2 -> frame 2 completes, o_frame_cnt=2, no third request.
- i_rst asserted mid-FRAME -> all outputs at reset values asynchronously; sys_res sequence repeats.
- With CMV_FRAME_TIMEOUT_EN defined and TIMEOUT_CYCLES=100, no LVAL -> o_timeout=1 after 100 cycles, READY, o_frame_cnt=0.
